// File: rtl/barreira_ctrl.sv
// Level-crossing barrier controller: two-track occupancy counting and barrier/lamp sequencing.
// Optional maintenance force-close input enabled by defining BARREIRA_MANUAL_EN.
//
// state   | meaning
// ABERTA  | barrier up, lamps dark, waiting for a train
// AVISO   | lamps flashing before the barrier moves
// DESCER  | motor lowering the barrier
// FECHADA | barrier down while any zone is occupied
// ESPERA  | barrier down, zones clear, hold before raising
// SUBIR   | motor raising the barrier
module barreira_ctrl #(
    parameter int WARN_CYC  = 8,
    parameter int MOVE_CYC  = 4,
    parameter int HOLD_CYC  = 6,
    parameter int BLINK_CYC = 2,
    parameter int OCC_W     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Entrada1,
    input  logic       Entrada2,
    input  logic       Saida1,
    input  logic       Saida2,
`ifdef BARREIRA_MANUAL_EN
    input  logic       ForcaFecho,
`endif
    output logic       Barreira,
    output logic       Luzes,
    output logic [1:0] Motor,
    output logic [2:0] Estado,
    output logic       Ocupado,
    output logic       Erro
);

    typedef enum logic [2:0] {
        ABERTA  = 3'd0,
        AVISO   = 3'd1,
        DESCER  = 3'd2,
        FECHADA = 3'd3,
        ESPERA  = 3'd4,
        SUBIR   = 3'd5
    } state_t;

    localparam int TMR_MAX = (WARN_CYC > MOVE_CYC)
                           ? ((WARN_CYC > HOLD_CYC) ? WARN_CYC : HOLD_CYC)
                           : ((MOVE_CYC > HOLD_CYC) ? MOVE_CYC : HOLD_CYC);
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam int BLK_W = $clog2(BLINK_CYC + 1);

    localparam logic [TMR_W-1:0] WARN_TC = TMR_W'(WARN_CYC - 1);
    localparam logic [TMR_W-1:0] MOVE_TC = TMR_W'(MOVE_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_TC = TMR_W'(HOLD_CYC - 1);
    localparam logic [BLK_W-1:0] BLK_TC  = BLK_W'(BLINK_CYC - 1);
    localparam logic [OCC_W-1:0] OCC_MAX = {OCC_W{1'b1}};

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   tmr;
    logic               timed;
    logic [BLK_W-1:0]   blk;
    logic [3:0]         sens, sens_q, edges;
    logic [OCC_W-1:0]   occ1, occ2, occ1_nxt, occ2_nxt;
    logic               err_nxt;
    logic               occ_any;

    // sensor order: {Saida2, Saida1, Entrada2, Entrada1}
    assign sens  = {Saida2, Saida1, Entrada2, Entrada1};
    assign edges = sens & ~sens_q;

    assign Ocupado = (occ1 != '0) | (occ2 != '0);
`ifdef BARREIRA_MANUAL_EN
    assign occ_any = Ocupado | ForcaFecho;
`else
    assign occ_any = Ocupado;
`endif
    assign Estado = state;

    // Simultaneous entry and exit on one track cancel out without flagging an error.
    always_comb begin
        occ1_nxt = occ1;
        occ2_nxt = occ2;
        err_nxt  = Erro;
        if (edges[0] & ~edges[2]) begin
            if (occ1 != OCC_MAX) occ1_nxt = occ1 + 1'b1;
        end else if (edges[2] & ~edges[0]) begin
            if (occ1 != '0) occ1_nxt = occ1 - 1'b1;
            else            err_nxt  = 1'b1;
        end
        if (edges[1] & ~edges[3]) begin
            if (occ2 != OCC_MAX) occ2_nxt = occ2 + 1'b1;
        end else if (edges[3] & ~edges[1]) begin
            if (occ2 != '0) occ2_nxt = occ2 - 1'b1;
            else            err_nxt  = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        timed     = 1'b0;
        case (state)
            ABERTA:  if (occ_any) state_nxt = AVISO;
            AVISO: begin
                timed = 1'b1;
                if (tmr == WARN_TC) state_nxt = DESCER;
            end
            DESCER: begin
                timed = 1'b1;
                if (tmr == MOVE_TC) state_nxt = FECHADA;
            end
            FECHADA: if (!occ_any) state_nxt = ESPERA;
            ESPERA: begin
                timed = 1'b1;
                if (occ_any)             state_nxt = FECHADA;
                else if (tmr == HOLD_TC) state_nxt = SUBIR;
            end
            SUBIR: begin
                timed = 1'b1;
                if (occ_any)             state_nxt = DESCER;
                else if (tmr == MOVE_TC) state_nxt = ABERTA;
            end
            default: state_nxt = ABERTA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ABERTA;
            tmr    <= '0;
            sens_q <= '0;
            occ1   <= '0;
            occ2   <= '0;
            Erro   <= 1'b0;
        end else begin
            state  <= state_nxt;
            sens_q <= sens;
            occ1   <= occ1_nxt;
            occ2   <= occ2_nxt;
            Erro   <= err_nxt;
            if (state_nxt != state) tmr <= '0;
            else if (timed)         tmr <= tmr + 1'b1;
        end
    end

    // Outputs follow the next state so they change together with Estado.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Barreira <= 1'b0;
            Motor    <= 2'b00;
            Luzes    <= 1'b0;
            blk      <= '0;
        end else begin
            Barreira <= (state_nxt == DESCER) | (state_nxt == FECHADA) | (state_nxt == ESPERA);
            Motor    <= (state_nxt == DESCER) ? 2'b01 :
                        (state_nxt == SUBIR)  ? 2'b10 : 2'b00;
            if (state_nxt == ABERTA) begin
                Luzes <= 1'b0;
                blk   <= '0;
            end else if (state == ABERTA) begin
                Luzes <= 1'b1;
                blk   <= '0;
            end else if (blk == BLK_TC) begin
                Luzes <= ~Luzes;
                blk   <= '0;
            end else begin
                blk   <= blk + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_barreira_ctrl.sv
// Directed self-checking bench for barreira_ctrl.
module tb_barreira_ctrl;
    localparam int WARN  = 8;
    localparam int MOVE  = 4;
    localparam int HOLD  = 6;
    localparam int BLINK = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Entrada1, Entrada2, Saida1, Saida2;
`ifdef BARREIRA_MANUAL_EN
    logic       ForcaFecho;
`endif
    logic       Barreira, Luzes, Ocupado, Erro;
    logic [1:0] Motor;
    logic [2:0] Estado;

    int n_chk  = 0;
    int n_fail = 0;
    int lcnt   = 0;

    always #5 clk = ~clk;

    barreira_ctrl #(
        .WARN_CYC(WARN), .MOVE_CYC(MOVE), .HOLD_CYC(HOLD), .BLINK_CYC(BLINK), .OCC_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Entrada1(Entrada1),
        .Entrada2(Entrada2),
        .Saida1(Saida1),
        .Saida2(Saida2),
`ifdef BARREIRA_MANUAL_EN
        .ForcaFecho(ForcaFecho),
`endif
        .Barreira(Barreira),
        .Luzes(Luzes),
        .Motor(Motor),
        .Estado(Estado),
        .Ocupado(Ocupado),
        .Erro(Erro)
    );

    // expected {Barreira, Motor} for a state code
    function automatic logic [2:0] exp_bm(input logic [2:0] st);
        case (st)
            3'd2:    return 3'b101;
            3'd3:    return 3'b100;
            3'd4:    return 3'b100;
            3'd5:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // lamp is 1 for the first BLINK cycles after leaving ABERTA, then alternates
    function automatic logic exp_luz(input int n);
        return ((n / BLINK) % 2) == 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        lcnt++;
    endtask

    task automatic do_reset();
        {Saida2, Saida1, Entrada2, Entrada1} = 4'b0000;
`ifdef BARREIRA_MANUAL_EN
        ForcaFecho = 1'b0;
`endif
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // mask order {Saida2, Saida1, Entrada2, Entrada1}: high one cycle, low one cycle
    task automatic pulse(input logic [3:0] m);
        {Saida2, Saida1, Entrada2, Entrada1} = m;
        tick();
        {Saida2, Saida1, Entrada2, Entrada1} = 4'b0000;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({Estado, Barreira, Luzes, Motor, Ocupado, Erro} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: estado=%0d bar=%b luz=%b mot=%b ocu=%b err=%b, want all 0",
                     Estado, Barreira, Luzes, Motor, Ocupado, Erro);
        end
    endtask

    task automatic test_close_open();
        logic [2:0] ph_st [3];
        int         ph_n  [3];
        do_reset();
        Entrada1 = 1'b1;
        tick();
        n_chk++;
        if (Ocupado !== 1'b1 || Estado !== 3'd0) begin
            n_fail++;
            $display("FAIL entry_ocupado: ocu=%b estado=%0d, want ocu=1 estado=0", Ocupado, Estado);
        end
        Entrada1 = 1'b0;
        tick();
        lcnt = 0;
        ph_st = '{3'd1, 3'd2, 3'd3};
        ph_n  = '{WARN, MOVE, 5};
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < ph_n[p]; i++) begin
                n_chk++;
                if (Estado !== ph_st[p] || {Barreira, Motor} !== exp_bm(ph_st[p]) || Luzes !== exp_luz(lcnt)) begin
                    n_fail++;
                    $display("FAIL close_seq st%0d cyc%0d: estado=%0d bm=%b luz=%b, want estado=%0d bm=%b luz=%b",
                             ph_st[p], i, Estado, {Barreira, Motor}, Luzes, ph_st[p], exp_bm(ph_st[p]), exp_luz(lcnt));
                end
                tick();
            end
        end
        Saida1 = 1'b1;
        tick();
        n_chk++;
        if (Ocupado !== 1'b0 || Estado !== 3'd3) begin
            n_fail++;
            $display("FAIL exit_clears: ocu=%b estado=%0d, want ocu=0 estado=3", Ocupado, Estado);
        end
        Saida1 = 1'b0;
        tick();
        ph_st[0] = 3'd4; ph_n[0] = HOLD;
        ph_st[1] = 3'd5; ph_n[1] = MOVE;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < ph_n[p]; i++) begin
                n_chk++;
                if (Estado !== ph_st[p] || {Barreira, Motor} !== exp_bm(ph_st[p]) || Luzes !== exp_luz(lcnt)) begin
                    n_fail++;
                    $display("FAIL open_seq st%0d cyc%0d: estado=%0d bm=%b luz=%b, want estado=%0d bm=%b luz=%b",
                             ph_st[p], i, Estado, {Barreira, Motor}, Luzes, ph_st[p], exp_bm(ph_st[p]), exp_luz(lcnt));
                end
                tick();
            end
        end
        n_chk++;
        if ({Estado, Barreira, Luzes, Motor} !== 7'd0) begin
            n_fail++;
            $display("FAIL back_open: estado=%0d bar=%b luz=%b mot=%b, want all 0", Estado, Barreira, Luzes, Motor);
        end
    endtask

    task automatic test_two_tracks();
        do_reset();
        pulse(4'b0011);
        lcnt = 1;
        repeat (WARN + MOVE) tick();
        pulse(4'b0100);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (Estado !== 3'd3 || Ocupado !== 1'b1 || Barreira !== 1'b1) begin
                n_fail++;
                $display("FAIL track2_holds cyc%0d: estado=%0d ocu=%b bar=%b, want estado=3 ocu=1 bar=1",
                         i, Estado, Ocupado, Barreira);
            end
            tick();
        end
        pulse(4'b1000);
        n_chk++;
        if (Estado !== 3'd4 || Ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL both_clear: estado=%0d ocu=%b, want estado=4 ocu=0", Estado, Ocupado);
        end
    endtask

    task automatic test_reentry();
        do_reset();
        Entrada1 = 1'b1;
        tick();
        Entrada1 = 1'b0;
        tick();
        lcnt = 0;
        repeat (WARN + MOVE) tick();
        pulse(4'b0100);
        repeat (HOLD) tick();
        tick();
        Entrada2 = 1'b1;
        tick();
        n_chk++;
        if (Estado !== 3'd5 || Ocupado !== 1'b1 || Motor !== 2'b10) begin
            n_fail++;
            $display("FAIL subir_entry: estado=%0d ocu=%b mot=%b, want estado=5 ocu=1 mot=10", Estado, Ocupado, Motor);
        end
        Entrada2 = 1'b0;
        tick();
        for (int i = 0; i < MOVE; i++) begin
            n_chk++;
            if (Estado !== 3'd2 || {Barreira, Motor} !== 3'b101 || Luzes !== exp_luz(lcnt)) begin
                n_fail++;
                $display("FAIL relower cyc%0d: estado=%0d bm=%b luz=%b, want estado=2 bm=101 luz=%b",
                         i, Estado, {Barreira, Motor}, Luzes, exp_luz(lcnt));
            end
            tick();
        end
        n_chk++;
        if (Estado !== 3'd3 || Motor !== 2'b00) begin
            n_fail++;
            $display("FAIL relower_done: estado=%0d mot=%b, want estado=3 mot=00", Estado, Motor);
        end
        pulse(4'b1000);
        tick();
        tick();
        Entrada1 = 1'b1;
        tick();
        n_chk++;
        if (Estado !== 3'd4 || Ocupado !== 1'b1) begin
            n_fail++;
            $display("FAIL espera_entry: estado=%0d ocu=%b, want estado=4 ocu=1", Estado, Ocupado);
        end
        Entrada1 = 1'b0;
        tick();
        n_chk++;
        if (Estado !== 3'd3 || Barreira !== 1'b1 || Luzes !== exp_luz(lcnt)) begin
            n_fail++;
            $display("FAIL espera_back: estado=%0d bar=%b luz=%b, want estado=3 bar=1 luz=%b",
                     Estado, Barreira, Luzes, exp_luz(lcnt));
        end
    endtask

    task automatic test_counters();
        do_reset();
        pulse(4'b0001);
        pulse(4'b0001);
        pulse(4'b0101);
        pulse(4'b0100);
        n_chk++;
        if (Ocupado !== 1'b1 || Erro !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_edge: ocu=%b err=%b, want ocu=1 err=0 (one train left)", Ocupado, Erro);
        end
        pulse(4'b0100);
        n_chk++;
        if (Ocupado !== 1'b0 || Erro !== 1'b0) begin
            n_fail++;
            $display("FAIL last_exit: ocu=%b err=%b, want ocu=0 err=0", Ocupado, Erro);
        end
        pulse(4'b0100);
        n_chk++;
        if (Ocupado !== 1'b0 || Erro !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_exit: ocu=%b err=%b, want ocu=0 err=1", Ocupado, Erro);
        end
        repeat (5) tick();
        n_chk++;
        if (Erro !== 1'b1) begin
            n_fail++;
            $display("FAIL erro_sticky: err=%b, want 1", Erro);
        end
        pulse(4'b1000);
        n_chk++;
        if (Erro !== 1'b1 || Ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL track2_empty_exit: err=%b ocu=%b, want err=1 ocu=0", Erro, Ocupado);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (8) pulse(4'b0001);
        n_chk++;
        if (Ocupado !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_entries: ocu=%b, want 1", Ocupado);
        end
        repeat (6) pulse(4'b0100);
        n_chk++;
        if (Ocupado !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_six_exits: ocu=%b, want 1", Ocupado);
        end
        pulse(4'b0100);
        n_chk++;
        if (Ocupado !== 1'b0 || Erro !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_seven_exits: ocu=%b err=%b, want ocu=0 err=0", Ocupado, Erro);
        end
        pulse(4'b0100);
        n_chk++;
        if (Erro !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_eighth_exit: err=%b, want 1", Erro);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse(4'b0001);
        repeat (WARN + 1) tick();
        n_chk++;
        if (Estado !== 3'd2 || Motor !== 2'b01) begin
            n_fail++;
            $display("FAIL pre_reset_descer: estado=%0d mot=%b, want estado=2 mot=01", Estado, Motor);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({Estado, Barreira, Luzes, Motor, Ocupado, Erro} !== 9'd0) begin
            n_fail++;
            $display("FAIL async_reset: estado=%0d bar=%b luz=%b mot=%b ocu=%b err=%b, want all 0",
                     Estado, Barreira, Luzes, Motor, Ocupado, Erro);
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_chk++;
        if (Estado !== 3'd0 || Motor !== 2'b00) begin
            n_fail++;
            $display("FAIL after_reset: estado=%0d mot=%b, want estado=0 mot=00", Estado, Motor);
        end
    endtask

`ifdef BARREIRA_MANUAL_EN
    task automatic test_manual();
        do_reset();
        ForcaFecho = 1'b1;
        tick();
        lcnt = 0;
        n_chk++;
        if (Estado !== 3'd1 || Ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL force_warn: estado=%0d ocu=%b, want estado=1 ocu=0", Estado, Ocupado);
        end
        repeat (WARN + MOVE + 3) tick();
        n_chk++;
        if (Estado !== 3'd3 || Barreira !== 1'b1 || Ocupado !== 1'b0 || Erro !== 1'b0) begin
            n_fail++;
            $display("FAIL force_closed: estado=%0d bar=%b ocu=%b err=%b, want estado=3 bar=1 ocu=0 err=0",
                     Estado, Barreira, Ocupado, Erro);
        end
        ForcaFecho = 1'b0;
        tick();
        n_chk++;
        if (Estado !== 3'd4) begin
            n_fail++;
            $display("FAIL force_release: estado=%0d, want 4", Estado);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_close_open();
        test_two_tracks();
        test_reentry();
        test_counters();
        test_saturation();
        test_reset_mid();
`ifdef BARREIRA_MANUAL_EN
        test_manual();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
